// File: rtl/monitor_secuencia_pkg.sv
// Shared definitions for the JK-counter sequence monitor: state encoding,
// the 0-4-14-6-3-12-11-13 cycle and lookup helpers over 4-bit codes.
package monitor_secuencia_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } estado_t;

    localparam int unsigned LARGO_SEC = 8;
    localparam logic [3:0] SECUENCIA [LARGO_SEC] = '{
        4'd0, 4'd4, 4'd14, 4'd6, 4'd3, 4'd12, 4'd11, 4'd13
    };

    function automatic logic es_legal(input logic [3:0] codigo);
        logic r;
        r = 1'b0;
        for (int i = 0; i < int'(LARGO_SEC); i++) begin
            if (SECUENCIA[i] == codigo) r = 1'b1;
        end
        return r;
    endfunction

    // Codes outside the cycle map to index 0; callers gate on es_legal.
    function automatic logic [2:0] indice(input logic [3:0] codigo);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < int'(LARGO_SEC); i++) begin
            if (SECUENCIA[i] == codigo) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] siguiente(input logic [3:0] codigo);
        logic [2:0] pos;
        pos = indice(codigo) + 3'd1;
        return SECUENCIA[pos];
    endfunction

endpackage

// File: rtl/monitor_secuencia_if.sv
// Sample bus between the counter under test and its monitor.
interface monitor_secuencia_if #(
    parameter int unsigned W_CNT = 8
);
    logic             EN;
    logic [3:0]       Q;
    logic             LOCK;
    logic [2:0]       POS;
    logic             ERR;
    logic             ILEGAL;
    logic             FAULT;
    logic [W_CNT-1:0] ERRORES;
    logic [W_CNT-1:0] VUELTAS;

    modport master (
        output EN, Q,
        input  LOCK, POS, ERR, ILEGAL, FAULT, ERRORES, VUELTAS
    );

    modport slave (
        input  EN, Q,
        output LOCK, POS, ERR, ILEGAL, FAULT, ERRORES, VUELTAS
    );
endinterface

// File: rtl/monitor_secuencia_tabla_secuencia.sv
// Combinational lookup of a 4-bit code: legality, cycle index and successor.
module tabla_secuencia
    import monitor_secuencia_pkg::*;
(
    input  logic [3:0] codigo,
    output logic       esLegal_c,
    output logic [2:0] indice_c,
    output logic [3:0] sucesor_c
);

    always_comb begin
        esLegal_c = es_legal(codigo);
        indice_c  = indice(codigo);
        sucesor_c = siguiente(codigo);
    end

endmodule

// File: rtl/monitor_secuencia.sv
// Registered checker for the arbitrary-sequence JK counter: tracks lock,
// position, mismatches, illegal codes, laps and a sticky fault.
module monitor_secuencia
    import monitor_secuencia_pkg::*;
#(
    parameter int unsigned MAX_ERR = 3,
    parameter int unsigned W_CNT   = 8
) (
    input  logic C,
    input  logic R,
    monitor_secuencia_if.slave bus
);

    localparam int unsigned W_CONSEC = (MAX_ERR < 2) ? 1 : $clog2(MAX_ERR + 1);
    localparam logic [W_CNT-1:0]    CNT_MAX    = '1;
    localparam logic [W_CONSEC-1:0] CONSEC_LIM = W_CONSEC'(MAX_ERR);

    estado_t             estado, estadoSig;
    logic [3:0]          prevQ, prevSig;
    logic [W_CONSEC-1:0] consec, consecSig;
    logic                lockR, lockSig;
    logic [2:0]          posR, posSig;
    logic                errR, errSig;
    logic                ilegalR, ilegalSig;
    logic                faultR, faultSig;
    logic [W_CNT-1:0]    errores, erroresSig;
    logic [W_CNT-1:0]    vueltas, vueltasSig;

    logic       qLegal;
    logic [2:0] qIndice;
    logic [3:0] unusedSucesorQ;
    logic       prevLegal;
    logic [2:0] unusedIndicePrev;
    logic [3:0] prevSucesor;

    tabla_secuencia tablaQ (
        .codigo    (bus.Q),
        .esLegal_c (qLegal),
        .indice_c  (qIndice),
        .sucesor_c (unusedSucesorQ)
    );

    tabla_secuencia tablaPrev (
        .codigo    (prevQ),
        .esLegal_c (prevLegal),
        .indice_c  (unusedIndicePrev),
        .sucesor_c (prevSucesor)
    );

    // State and every output register; reset clears all of it.
    always_ff @(posedge C) begin
        if (R) begin
            estado  <= SYNC;
            prevQ   <= 4'd0;
            consec  <= '0;
            lockR   <= 1'b0;
            posR    <= 3'd0;
            errR    <= 1'b0;
            ilegalR <= 1'b0;
            faultR  <= 1'b0;
            errores <= '0;
            vueltas <= '0;
        end else begin
            estado  <= estadoSig;
            prevQ   <= prevSig;
            consec  <= consecSig;
            lockR   <= lockSig;
            posR    <= posSig;
            errR    <= errSig;
            ilegalR <= ilegalSig;
            faultR  <= faultSig;
            errores <= erroresSig;
            vueltas <= vueltasSig;
        end
    end

    always_comb begin
        estadoSig  = estado;
        prevSig    = prevQ;
        consecSig  = consec;
        lockSig    = lockR;
        posSig     = posR;
        errSig     = 1'b0;
        ilegalSig  = 1'b0;
        faultSig   = faultR;
        erroresSig = errores;
        vueltasSig = vueltas;

        if (bus.EN) begin
            case (estado)
                SYNC: begin
                    if (qLegal) begin
                        prevSig   = bus.Q;
                        posSig    = qIndice;
                        estadoSig = TRACK;
                        lockSig   = 1'b1;
                    end else begin
                        ilegalSig = 1'b1;
                    end
                end
                TRACK: begin
                    if (prevLegal && (bus.Q == prevSucesor)) begin
                        prevSig   = bus.Q;
                        posSig    = qIndice;
                        consecSig = '0;
                        if ((prevQ == 4'd13) && (bus.Q == 4'd0) && (vueltas != CNT_MAX))
                            vueltasSig = vueltas + W_CNT'(1);
                    end else begin
                        errSig    = 1'b1;
                        consecSig = consec + W_CONSEC'(1);
                        if (errores != CNT_MAX)
                            erroresSig = errores + W_CNT'(1);
                        if (qLegal) begin
                            prevSig = bus.Q;
                            posSig  = qIndice;
                        end else begin
                            ilegalSig = 1'b1;
                            estadoSig = SYNC;
                            lockSig   = 1'b0;
                        end
                        // Reaching the limit overrides the drop back to SYNC.
                        if (consecSig == CONSEC_LIM) begin
                            estadoSig = FAULT;
                            faultSig  = 1'b1;
                            lockSig   = 1'b0;
                        end
                    end
                end
                FAULT: begin
                end
                default: begin
                    estadoSig = SYNC;
                end
            endcase
        end
    end

    assign bus.LOCK    = lockR;
    assign bus.POS     = posR;
    assign bus.ERR     = errR;
    assign bus.ILEGAL  = ilegalR;
    assign bus.FAULT   = faultR;
    assign bus.ERRORES = errores;
    assign bus.VUELTAS = vueltas;

endmodule

// File: tb/tb_monitor_secuencia.sv
// Scoreboard bench: two monitors (8-bit and 2-bit counters) share one stimulus.
module tb_monitor_secuencia;

    typedef struct packed {
        logic       lock;
        logic [2:0] pos;
        logic       err;
        logic       ilg;
        logic       flt;
        logic [7:0] errores;
        logic [7:0] vueltas;
        logic [1:0] erroresB;
        logic [1:0] vueltasB;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] q;

    obs_t  expQ [$];
    string tagQ [$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    monitor_secuencia_if #(.W_CNT(8)) busA ();
    monitor_secuencia_if #(.W_CNT(2)) busB ();

    assign busA.EN = en;
    assign busA.Q  = q;
    assign busB.EN = en;
    assign busB.Q  = q;

    monitor_secuencia #(.MAX_ERR(3), .W_CNT(8)) dutA (.C(clk), .R(rst), .bus(busA));
    monitor_secuencia #(.MAX_ERR(3), .W_CNT(2)) dutB (.C(clk), .R(rst), .bus(busB));

    function automatic logic [1:0] sat2(input logic [7:0] v);
        return (v > 8'd3) ? 2'd3 : v[1:0];
    endfunction

    // Drive one sample on the falling edge and queue the response due after the next rising edge.
    task automatic paso(input logic r_, input logic en_, input logic [3:0] q_,
                        input logic lk, input logic [2:0] ps, input logic e,
                        input logic il, input logic f, input logic [7:0] ers,
                        input logic [7:0] vts, input string tag);
        obs_t x;
        @(negedge clk);
        rst = r_;
        en  = en_;
        q   = q_;
        x.lock     = lk;
        x.pos      = ps;
        x.err      = e;
        x.ilg      = il;
        x.flt      = f;
        x.errores  = ers;
        x.vueltas  = vts;
        x.erroresB = sat2(ers);
        x.vueltasB = sat2(vts);
        expQ.push_back(x);
        tagQ.push_back(tag);
    endtask

    // Monitor: compare one queued expectation per clock.
    always begin
        obs_t  act;
        obs_t  ex;
        string tg;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            ex  = expQ.pop_front();
            tg  = tagQ.pop_front();
            act = {busA.LOCK, busA.POS, busA.ERR, busA.ILEGAL, busA.FAULT,
                   busA.ERRORES, busA.VUELTAS, busB.ERRORES, busB.VUELTAS};
            total++;
            if (act !== ex) begin
                bad++;
                $display("FAIL %s: got lock=%b pos=%0d err=%b ilg=%b flt=%b errs=%0d laps=%0d errsB=%0d lapsB=%0d, expected lock=%b pos=%0d err=%b ilg=%b flt=%b errs=%0d laps=%0d errsB=%0d lapsB=%0d",
                         tg, act.lock, act.pos, act.err, act.ilg, act.flt, act.errores,
                         act.vueltas, act.erroresB, act.vueltasB, ex.lock, ex.pos, ex.err,
                         ex.ilg, ex.flt, ex.errores, ex.vueltas, ex.erroresB, ex.vueltasB);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] vuelta [8];
        vuelta = '{4'd4, 4'd14, 4'd6, 4'd3, 4'd12, 4'd11, 4'd13, 4'd0};
        rst = 1'b1;
        en  = 1'b0;
        q   = 4'd0;

        //   r  en  q      lk pos err ilg flt errs laps
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset");
        // Clean lap
        paso(0, 1, 4'd0,   1, 0, 0, 0, 0, 0, 0, "clean_q0");
        paso(0, 1, 4'd4,   1, 1, 0, 0, 0, 0, 0, "clean_q4");
        paso(0, 1, 4'd14,  1, 2, 0, 0, 0, 0, 0, "clean_q14");
        paso(0, 1, 4'd6,   1, 3, 0, 0, 0, 0, 0, "clean_q6");
        paso(0, 1, 4'd3,   1, 4, 0, 0, 0, 0, 0, "clean_q3");
        paso(0, 1, 4'd12,  1, 5, 0, 0, 0, 0, 0, "clean_q12");
        paso(0, 1, 4'd11,  1, 6, 0, 0, 0, 0, 0, "clean_q11");
        paso(0, 1, 4'd13,  1, 7, 0, 0, 0, 0, 0, "clean_q13");
        paso(0, 1, 4'd0,   1, 0, 0, 0, 0, 0, 1, "clean_lap");

        // Illegal code while searching, then lock and an EN gap
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset2");
        paso(0, 1, 4'd5,   0, 0, 0, 1, 0, 0, 0, "sync_illegal");
        paso(0, 1, 4'd3,   1, 4, 0, 0, 0, 0, 0, "sync_lock3");
        paso(0, 1, 4'd12,  1, 5, 0, 0, 0, 0, 0, "sync_next12");
        paso(0, 0, 4'd9,   1, 5, 0, 0, 0, 0, 0, "en_low_hold");
        paso(0, 1, 4'd11,  1, 6, 0, 0, 0, 0, 0, "en_gap_next11");

        // Skipped value, resync, consecutive-count clearing, illegal in TRACK
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset3");
        paso(0, 1, 4'd4,   1, 1, 0, 0, 0, 0, 0, "skip_lock4");
        paso(0, 1, 4'd6,   1, 3, 1, 0, 0, 1, 0, "skip_err");
        paso(0, 1, 4'd3,   1, 4, 0, 0, 0, 1, 0, "skip_accept3");
        paso(0, 1, 4'd3,   1, 4, 1, 0, 0, 2, 0, "repeat3_err");
        paso(0, 1, 4'd12,  1, 5, 0, 0, 0, 2, 0, "accept12");
        paso(0, 1, 4'd12,  1, 5, 1, 0, 0, 3, 0, "repeat12_a");
        paso(0, 1, 4'd12,  1, 5, 1, 0, 0, 4, 0, "repeat12_b");
        paso(0, 1, 4'd11,  1, 6, 0, 0, 0, 4, 0, "accept11");
        paso(0, 1, 4'd9,   0, 6, 1, 1, 0, 5, 0, "track_illegal");
        paso(0, 1, 4'd13,  1, 7, 0, 0, 0, 5, 0, "relock13");
        paso(0, 1, 4'd0,   1, 0, 0, 0, 0, 5, 1, "lap_after_relock");
        paso(0, 1, 4'd0,   1, 0, 1, 0, 0, 6, 1, "stuck0_a");
        paso(0, 1, 4'd0,   1, 0, 1, 0, 0, 7, 1, "stuck0_b");
        paso(0, 1, 4'd0,   0, 0, 1, 0, 1, 8, 1, "stuck0_fault");

        // Stuck counter from reset
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset4");
        paso(0, 1, 4'd4,   1, 1, 0, 0, 0, 0, 0, "stuck4_1");
        paso(0, 1, 4'd4,   1, 1, 1, 0, 0, 1, 0, "stuck4_2");
        paso(0, 1, 4'd4,   1, 1, 1, 0, 0, 2, 0, "stuck4_3");
        paso(0, 1, 4'd4,   0, 1, 1, 0, 1, 3, 0, "stuck4_4_fault");
        paso(0, 1, 4'd4,   0, 1, 0, 0, 1, 3, 0, "fault_hold_4");
        paso(0, 1, 4'd14,  0, 1, 0, 0, 1, 3, 0, "fault_hold_14");
        paso(0, 1, 4'd9,   0, 1, 0, 0, 1, 3, 0, "fault_hold_9");

        // Reset coincident with a mismatching illegal sample
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset5");
        paso(0, 1, 4'd0,   1, 0, 0, 0, 0, 0, 0, "rmid_lock0");
        paso(0, 1, 4'd4,   1, 1, 0, 0, 0, 0, 0, "rmid_4");
        paso(1, 1, 4'd9,   0, 0, 0, 0, 0, 0, 0, "rmid_reset_wins");
        paso(0, 1, 4'd7,   0, 0, 0, 1, 0, 0, 0, "rmid_in_sync");
        paso(0, 1, 4'd6,   1, 3, 0, 0, 0, 0, 0, "rmid_relock6");

        // Four laps: 8-bit lap count reaches 4, 2-bit one saturates at 3
        paso(1, 0, 4'd0,   0, 0, 0, 0, 0, 0, 0, "reset6");
        paso(0, 1, 4'd0,   1, 0, 0, 0, 0, 0, 0, "sat_lock0");
        for (int lap = 1; lap <= 4; lap++) begin
            for (int i = 0; i < 8; i++) begin
                paso(0, 1, vuelta[i], 1, 3'(i + 1), 0, 0, 0, 0,
                     (i == 7) ? 8'(lap) : 8'(lap - 1), $sformatf("sat_lap%0d_step%0d", lap, i));
            end
        end

        @(posedge clk);
        #3;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monitor_secuencia.md
# monitor_secuencia

Registered checker that sits directly downstream of the 4-bit arbitrary-sequence JK counter. It samples the counter's `Q` bus each clock and verifies that it follows the fixed sequence 0→4→14→6→3→12→11→13→0. It reports lock status, per-sample mismatch and illegal-code pulses, saturating error and lap counts, and a sticky fault once the counter misbehaves repeatedly.

## Interface
Parameters:
- `MAX_ERR`, default 3: consecutive mismatches in TRACK that cause FAULT; must be ≥1.
- `W_CNT`, default 8: width of the `ERRORES` and `VUELTAS` counters.

Ports:
- `C`  in  1  clock; all state updates on its rising edge. One clock; reset is synchronous and active-high.
- `R`  in  1  synchronous, active-high reset; overrides every other input.
- `EN`  in  1  sample qualifier; `Q` is evaluated only on edges where `EN`=1.
- `Q`  in  4  counter output under test.
- `LOCK`  out  1  level; 1 while in TRACK.
- `POS`  out  3  index of the last accepted value in the sequence: 0→0, 4→1, 14→2, 6→3, 3→4, 12→5, 11→6, 13→7.
- `ERR`  out  1  one-cycle pulse on a mismatch in TRACK.
- `ILEGAL`  out  1  one-cycle pulse when a sampled code is outside the sequence (1, 2, 5, 7, 8, 9, 10, 15).
- `FAULT`  out  1  sticky; cleared only by `R`.
- `ERRORES`  out  `W_CNT`  saturating mismatch count.
- `VUELTAS`  out  `W_CNT`  saturating count of completed laps.

## Operation
- Internal registers: state, `prev` (4 bits), and `consec` (consecutive-mismatch count, ⌈log2(MAX_ERR+1)⌉ bits).
- Reset (`R`=1 at an edge):
  - state ← SYNC; `prev` ← 0; `consec` ← 0.
  - All outputs ← 0.
- `EN`=0: all registers hold. Pulse outputs drop to 0.
- SYNC, `EN`=1:
  - Legal sample: `prev` ← `Q`, `POS` ← index(`Q`), state ← TRACK.
  - Illegal sample: `ILEGAL` pulses; stay in SYNC.
- TRACK, `EN`=1; expected value = successor(`prev`).
  - Match:
    - `prev` ← `Q`, `POS` updated, `consec` ← 0.
    - If `prev`=13 and `Q`=0, `VUELTAS` increments.
  - Mismatch, legal code:
    - `ERR` pulses, `ERRORES` increments, `consec` increments.
    - Resync: `prev` ← `Q`, `POS` ← index(`Q`).
  - Mismatch, illegal code:
    - `ERR` and `ILEGAL` both pulse; `ERRORES` and `consec` increment.
    - State ← SYNC; `LOCK` ← 0; `prev` and `POS` hold.
  - Threshold: if `consec` reaches `MAX_ERR` on this edge, state ← FAULT. FAULT takes priority over the SYNC transition.
- FAULT:
  - `FAULT`=1 and `LOCK`=0.
  - `ERR` and `ILEGAL` stay 0; all counters and `POS` freeze.
  - Exit only via `R`.
- Counters saturate at 2^`W_CNT`−1 and never wrap.
- A stuck counter (same legal value sampled repeatedly) counts as a mismatch on every sample after the first.

## Timing
- All outputs are registered. The response to a sample taken at edge k is visible after edge k, with no combinational path from `Q` to any output.
- `LOCK` rises on the edge that accepts the first legal sample in SYNC.
- The lap count updates on the same edge as the 13→0 match.
- `FAULT` asserts on the same edge as the `MAX_ERR`-th consecutive `ERR` pulse; that pulse is still emitted and counted.
- `R` together with any `Q` or `EN`: reset wins, with no pulse and no count.
- `EN` low between samples does not break the sequence; the next `EN`=1 sample is checked against successor(`prev`).

## Structure
- Shared package:
  - state encoding (SYNC, TRACK, FAULT);
  - the 8-entry sequence constant;
  - functions `es_legal`, `indice`, `siguiente` over 4-bit codes.
- One natural combinational sub-module, `tabla_secuencia`: input a 4-bit code; outputs legal flag, 3-bit index, and 4-bit successor.
  - Instantiated twice: once on `Q` and once on `prev`.
- The remainder is a single FSM plus counters in `monitor_secuencia`.

## Test plan
- Clean run. Stimulus: `R`, then `EN`=1 with `Q`=0,4,14,6,3,12,11,13,0. Required response:
  - `LOCK`=1 from the first edge; `POS`=0,1,2,3,4,5,6,7,0.
  - `ERR` never pulses; `VUELTAS`=1; `ERRORES`=0.
- Illegal code in SYNC. Stimulus: `Q`=5, then 3. Required response:
  - `ILEGAL` pulses on the first edge with `LOCK`=0.
  - Second edge: `LOCK`=1, `POS`=4; next `Q`=12 is accepted.
- Skipped value. Stimulus: lock at 4, then `Q`=6. Required response:
  - `ERR` pulses, `ERRORES`=1, `POS`=3.
  - Following `Q`=3 is accepted and `consec` returns to 0.
- Stuck counter, `MAX_ERR`=3. Stimulus: `Q`=4,4,4,4. Required response:
  - `ERR` pulses on samples 2, 3 and 4.
  - `FAULT`=1 and `LOCK`=0 after sample 4, with `ERRORES`=3.
  - Afterwards `FAULT` stays set and `ERRORES` stays 3 until `R`.
- Reset mid-TRACK. Stimulus: `R`=1 coincident with mismatching `Q`=9. Required response:
  - No `ERR` or `ILEGAL` pulse.
  - All outputs 0 after the edge; state SYNC.
- Saturation, `W_CNT`=2. Stimulus: 4 full laps. Required response: `VUELTAS` reaches 3 and stays at 3.
